clause_stream_ctrl: RTL

//  Memory-side clause streamer: the transmitter that drives the clause arbiter (carb) mem2carb_* interface.

---
 rtl/sat_pkg.sv | 30 +++
 rtl/clause_table.sv | 31 +++
 rtl/clause_stream_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared types and sizing for the clause streamer and its clause table.
package sat_pkg;

  localparam int NUM_CLAUSE = 16;
  localparam int LIT_W      = 11;
  localparam int CLA_LEN    = 3;
  localparam int CW         = $clog2(NUM_CLAUSE);

  // Table depth expressed at the width of num_cla, for saturating compares.
  localparam logic [CW:0] NUM_CLAUSE_W = (CW+1)'(NUM_CLAUSE);

  // One literal, two's complement; zero marks an empty literal slot.
  typedef logic signed [LIT_W-1:0] lit_t;

  // One clause, lit[0] in the least significant bits.
  typedef logic [CLA_LEN*LIT_W-1:0] cla_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  // Clamp a requested clause count to the table depth.
  function automatic logic [CW:0] clamp_num(input logic [CW:0] n);
    return (n > NUM_CLAUSE_W) ? NUM_CLAUSE_W : n;
  endfunction

endpackage

// File: rtl/clause_table.sv
// Clause table: NUM_CLAUSE x cla_t register file, one write port,
// one combinational read port, asynchronous clear.
module clause_table
  import sat_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  cla_t          wdata,
  input  logic [CW-1:0] raddr,
  output cla_t          rdata
);

  cla_t mem [NUM_CLAUSE];

  // Store host writes; the whole table clears on reset.
  // NOTE: this table is built from flops, so it can take an async clear; a RAM macro could not be reset like this.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_CLAUSE; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/clause_stream_ctrl.sv
// Clause streamer: replays the host-loaded clause table into the clause
// arbiter one clause per cycle, then watches carb_empty/conflict to report
// completion or conflict back to the host. rst_n is active-high.
module clause_stream_ctrl
  import sat_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_we,
  input  logic [CW-1:0] host_addr,
  input  cla_t          host_clause,
  input  logic          host_uc_we,
  input  lit_t          host_uc,
  input  logic [CW:0]   num_cla,
  input  logic          go,
  input  logic          carb_stall,
  input  logic          carb_empty,
  input  logic          conflict,
  output logic          mem2carb_start,
  output logic          mem2carb_finish,
  output cla_t          mem2carb_clause,
  output logic          mem2carb_uc_valid,
  output lit_t          mem2carb_uc,
  output logic          busy,
  output logic          done,
  output logic          sat_conflict
);

  stream_state_t state;
  logic [CW:0]   cnt;         // clauses in this pass, saturated
  logic [CW:0]   rd_ptr;      // next table entry to issue; stops at cnt
  logic          first_beat;  // next issued beat carries the unit clause
  logic          empty_seen;  // carb was idle on the previous DRAIN cycle
  lit_t          uc_reg;
  cla_t          rd_clause;
  logic          table_we;
  logic          last_beat;

  // Host writes only land while idle, so the table is stable during a pass.
  assign table_we  = host_we && (state == IDLE);
  assign last_beat = (rd_ptr == cnt - 1'b1);
  assign busy      = (state == STREAM) || (state == DRAIN);

  clause_table u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (table_we),
    .waddr (host_addr),
    .wdata (host_clause),
    .raddr (rd_ptr[CW-1:0]),
    .rdata (rd_clause)
  );

  // Initial unit-clause register, loadable only while idle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      uc_reg <= '0;
    end else if (host_uc_we && (state == IDLE)) begin
      uc_reg <= host_uc;
    end
  end

  // Pass FSM and registered mem2carb outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      rd_ptr            <= '0;
      first_beat        <= 1'b0;
      empty_seen        <= 1'b0;
      mem2carb_start    <= 1'b0;
      mem2carb_finish   <= 1'b0;
      mem2carb_clause   <= '0;
      mem2carb_uc_valid <= 1'b0;
      mem2carb_uc       <= '0;
      done              <= 1'b0;
      sat_conflict      <= 1'b0;
    end else begin
      // Beat strobes default low; payloads hold their last value.
      // NOTE: non-blocking assignments let later branches override these defaults without ordering races.
      mem2carb_start    <= 1'b0;
      mem2carb_finish   <= 1'b0;
      mem2carb_uc_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            cnt          <= clamp_num(num_cla);
            rd_ptr       <= '0;
            first_beat   <= 1'b1;
            done         <= 1'b0;
            sat_conflict <= 1'b0;
            state        <= STREAM;
          end
        end

        STREAM: begin
          if (conflict) begin
            sat_conflict <= 1'b1;
            state        <= IDLE;
          end else if (!carb_stall) begin
            if (cnt == '0) begin
              // Empty pass: a single finish beat carrying only the unit clause.
              mem2carb_finish   <= 1'b1;
              mem2carb_uc_valid <= 1'b1;
              mem2carb_uc       <= uc_reg;
              empty_seen        <= 1'b0;
              state             <= DRAIN;
            end else begin
              mem2carb_start    <= 1'b1;
              mem2carb_clause   <= rd_clause;
              mem2carb_finish   <= last_beat;
              mem2carb_uc_valid <= first_beat;
              if (first_beat) begin
                mem2carb_uc <= uc_reg;
              end
              first_beat <= 1'b0;
              rd_ptr     <= rd_ptr + 1'b1;
              if (last_beat) begin
                empty_seen <= 1'b0;
                state      <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          if (conflict) begin
            sat_conflict <= 1'b1;
            state        <= IDLE;
          end else if (carb_empty) begin
            if (empty_seen) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              empty_seen <= 1'b1;
            end
          end else begin
            empty_seen <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
